rf_wb_arbiter: RTL

- Arbitrates the single register-file write port (wa/wr/wren) between two writeback requesters: A = ALU result, B = load/memory result.
- Registers the granted write and drives the register file's active-low write enable.
- Maintains a 32-bit pending-write scoreboard so the issue stage can stall on read-after-write hazards.
- Sits between the execute/memory stages and reg_file.

---
 rtl/rf_wb_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Arbitrates the single register-file write port between two writeback
//   requesters (A = ALU result, B = load result), registers the granted
//   write toward reg_file, and keeps a pending-write scoreboard so the
//   issue stage can stall on read-after-write hazards.
//
//   Build option: RF_WB_FIXED_PRIO_EN
//     defined   - fixed priority, B (load) wins every contended cycle
//     undefined - round-robin between A and B (default)
//
//   Ports
//     clk, rstd             clock / async active-low reset
//     a_valid/a_addr/a_data requester A write request; a_ready = accepted
//     b_valid/b_addr/b_data requester B write request; b_ready = accepted
//     sb_set, sb_set_addr   issue stage marks a register as pending
//     sb_busy               bit k = write to rk still outstanding
//     wa, wr, wren          registered reg_file write port (wren active-low)
module rf_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstd,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_set_addr,
    output logic [31:0]   sb_busy,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wr,
    output logic          wren
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    wb_req_t     sel;
    logic        acc;
    logic [31:0] sb_next;

    // ---------------------------------------------------------------
    // Grant selection. Readies are forced low during reset so nothing
    // is accepted while the block is being cleared.
    // ---------------------------------------------------------------
`ifdef RF_WB_FIXED_PRIO_EN
    assign b_ready = rstd & b_valid;
    assign a_ready = rstd & a_valid & ~b_valid;
`else
    // ptr_b=1: B wins the next contended cycle.
    logic ptr_b;

    assign a_ready = rstd & a_valid & (~b_valid | ~ptr_b);
    assign b_ready = rstd & b_valid & (~a_valid |  ptr_b);

    // Pointer moves only when both sides competed; the loser goes next.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd)
            ptr_b <= 1'b0;
        else if (a_valid && b_valid)
            ptr_b <= ~ptr_b;
    end
`endif

    assign acc      = a_ready | b_ready;
    assign sel.addr = a_ready ? a_addr : b_addr;
    assign sel.data = a_ready ? a_data : b_data;

    // ---------------------------------------------------------------
    // Registered write port. A grant to r0 is accepted (so the
    // requester can retire it) but never turns into a write.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            wren <= 1'b1;
            wa   <= '0;
            wr   <= '0;
        end else if (acc && sel.addr != '0) begin
            wren <= 1'b0;
            wa   <= sel.addr;
            wr   <= sel.data;
        end else begin
            wren <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Scoreboard. A bit clears on the edge reg_file actually writes the
    // register (registered wren low). The set is applied after the clear
    // so a newer producer issued on that same edge keeps the bit busy.
    // ---------------------------------------------------------------
    always_comb begin
        sb_next = sb_busy;
        if (!wren)
            sb_next[wa] = 1'b0;
        if (sb_set && sb_set_addr != '0)
            sb_next[sb_set_addr] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd)
            sb_busy <= '0;
        else
            sb_busy <= sb_next;
    end

endmodule
